sd_line_ctrl: RTL and testbench
===============================

Name: sd_line_ctrl

Overview:
- Timing and sequencing controller for the 1-bit ping-pong line-buffer scandoubler.
- Decodes the composite sync into line-start and vsync events, and measures the input line period.
- Tracks lock on the input timing and generates the buffer write/read addresses, bank toggle, output hsync/vsync, display-enable and scanline phase.
- Sits between the ZX81 video core (csync) and the line-buffer RAM/pixel mux; it contains no pixel storage itself.

Parameters:
- VSYNC_LEN, 90: sync-low length (in ce_2pix ticks) that qualifies as vsync.
- DEF_OUT_LEN, 414: output line length used while unlocked.
- MIN_LINE, 600: minimum valid input line period, in ticks.
- MAX_LINE, 1000: maximum valid input line period, in ticks; also the line-start watchdog timeout.
- HS_START, 384: output column at which hs_out goes low (active-low until line end).
- H_DE_START, 64: first output column with display enabled (inclusive).
- H_DE_END, 364: output column at which display enable ends (exclusive).
- V_DE_START, 16: first line with display enabled (inclusive).
- V_DE_END, 296: line at which display enable ends (exclusive).
- LOCK_LINES, 4: number of consecutive good lines needed to lock.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce_2pix  in  1  clock enable, twice the ZX pixel rate
- csync  in  1  composite sync, active-low
- wr_en  out  1  line-buffer write strobe
- wr_addr  out  10  {bank, input column[9:1]}
- rd_addr  out  10  {~bank, output column[8:0]}
- hs_out  out  1  output hsync, active-low
- vs_out  out  1  output vsync, active-high
- de  out  1  display enable (h_de AND v_de)
- scanline  out  1  odd-output-line phase, used for scanline darkening
- locked  out  1  input timing locked
- line_cnt  out  10  input line number since last vsync

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous and active-low. All state advances only when ce_2pix=1; outputs are registered, 1 ce of latency.
- Reset values: wr_en=0, wr_addr=0, rd_addr=0x200, hs_out=1, vs_out=0, de=0, scanline=0, locked=0, line_cnt=0; FSM=UNLOCKED; out_len=DEF_OUT_LEN; csD=1; sync_len=0.
- Sync decoding:
  - sync_len is an 8-bit counter. It clears while csync=1, and while csync=0 it increments, saturating at 255.
  - sync_len==VSYNC_LEN while csync=0: set vs_out=1, line_cnt=0, scanline=0.
  - vs_out clears on the first ce with csync=1.
  - line_start = csync & ~csD & (sync_len<VSYNC_LEN).
  - A rising edge at the end of a vsync is not a line start; it only resets in_col.
- Input side:
  - in_col (10-bit) resets on line_start or on the end of vsync; otherwise it increments, saturating at 1023.
  - wr_en = in_col[0]; wr_addr = {bank, in_col[9:1]}.
  - bank toggles on every line_start.
  - line_cnt increments on each line_start, saturating at 1023.
- Period measurement: on line_start, period = in_col + 1. good = MIN_LINE ≤ period ≤ MAX_LINE.
- FSM:
  - UNLOCKED → ACQUIRE on the first good line.
  - ACQUIRE: count consecutive good lines whose period differs from the previous period by ≤2. A bad line or mismatch sets count=0 and returns to UNLOCKED. When count reaches LOCK_LINES, go to LOCKED and latch out_len = period>>1.
  - LOCKED: a bad line or a watchdog timeout (in_col reaches MAX_LINE with no line_start) → UNLOCKED and out_len=DEF_OUT_LEN. A good line leaves out_len unchanged.
  - A vsync has no effect on the FSM.
  - locked = (FSM==LOCKED).
- Output side:
  - out_col (9-bit) resets on line_start, or when out_col==out_len-1; otherwise it increments. A wrap also toggles scanline.
  - rd_addr = {~bank, out_col}.
  - hs_out = ~(out_col ≥ HS_START).
  - de = (H_DE_START ≤ out_col < H_DE_END) & (V_DE_START ≤ line_cnt < V_DE_END).
- Simultaneous events:
  - line_start and wrap in the same ce: reset out_col once and toggle scanline once.
  - Vsync detection coinciding with a wrap: scanline=0 takes priority.
- out_len change: a new out_len takes effect from the next wrap; out_col is never truncated mid-line.
- Reset mid-line: everything returns to reset values immediately. The first line_start after reset is treated as a normal line start.

Decomposition:
- Shared package sd_pkg holds:
  - FSM state enum {UNLOCKED, ACQUIRE, LOCKED};
  - default timing constants (VSYNC_LEN, DEF_OUT_LEN, DE window values), so the scandoubler and the OSD use the same values.
- One natural sub-module, sd_sync_decode: holds csD and sync_len, and produces line_start, vsync_start and vsync_end.

Test Plan:
- Reset: with reset_n low, run 5 ce → hs_out=1, vs_out=0, locked=0, rd_addr=0x200. Then release and drive csync high → out_col wraps every 414 ce and scanline toggles each wrap.
- Lock: 6 lines of period 828 (hsync-low 40 ce) → locked=1 after the 5th line_start, out_len=414; bank alternates; wr_addr[8:0] ramps 0..413.
- Vsync: csync low for 120 ce → vs_out rises on the 91st low ce and falls on the first high ce; line_cnt=0, scanline=0, and there is no bank toggle.
- Jitter and unlock: while locked, periods 828/830 keep the lock; a single period 400 drops locked to 0 and resets out_len to 414.
- Watchdog: while locked, hold csync high for 1100 ce → locked=0 at in_col=MAX_LINE.
- Display-enable window: lock, then step to line_cnt=16 → de is high for out_col 64..363 only; at line_cnt 15 and at 296, de stays 0 for the whole line.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared scandoubler timing constants and lock state encoding
package sd_pkg;
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_state_t;
  localparam int SD_VSYNC_LEN   = 90;
  localparam int SD_DEF_OUT_LEN = 414;
  localparam int SD_MIN_LINE    = 600;
  localparam int SD_MAX_LINE    = 1000;
  localparam int SD_HS_START    = 384;
  localparam int SD_H_DE_START  = 64;
  localparam int SD_H_DE_END    = 364;
  localparam int SD_V_DE_START  = 16;
  localparam int SD_V_DE_END    = 296;
  localparam int SD_LOCK_LINES  = 4;
endpackage

// File: rtl/sd_sync_decode.sv
// sd_sync_decode: splits active-low composite sync into line-start and vsync events
module sd_sync_decode
  import sd_pkg::*;
#(
  parameter int VSYNC_LEN = SD_VSYNC_LEN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic csync,
  output logic line_start,
  output logic vsync_start,
  output logic vsync_end
);
  localparam logic [7:0] VS = 8'(VSYNC_LEN);
  logic       cs_d;
  logic [7:0] sync_len;
  logic       rising;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cs_d     <= 1'b1;
      sync_len <= '0;
    end else if (ce) begin
      cs_d     <= csync;
      sync_len <= csync ? '0 : sync_len + {7'd0, sync_len != 8'hff};
    end
  assign rising      = ce & csync & ~cs_d;
  assign line_start  = rising & (sync_len < VS);
  assign vsync_end   = rising & (sync_len >= VS);
  assign vsync_start = ce & ~csync & (sync_len == VS);
endmodule

// File: rtl/sd_line_ctrl.sv
// sd_line_ctrl: line-buffer scandoubler timing, lock tracking and output sync generation
module sd_line_ctrl
  import sd_pkg::*;
#(
  parameter int VSYNC_LEN   = SD_VSYNC_LEN,
  parameter int DEF_OUT_LEN = SD_DEF_OUT_LEN,
  parameter int MIN_LINE    = SD_MIN_LINE,
  parameter int MAX_LINE    = SD_MAX_LINE,
  parameter int HS_START    = SD_HS_START,
  parameter int H_DE_START  = SD_H_DE_START,
  parameter int H_DE_END    = SD_H_DE_END,
  parameter int V_DE_START  = SD_V_DE_START,
  parameter int V_DE_END    = SD_V_DE_END,
  parameter int LOCK_LINES  = SD_LOCK_LINES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_2pix,
  input  logic       csync,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [9:0] rd_addr,
  output logic       hs_out,
  output logic       vs_out,
  output logic       de,
  output logic       scanline,
  output logic       locked,
  output logic [9:0] line_cnt
);
  localparam logic [10:0] MIN_P  = 11'(MIN_LINE);
  localparam logic [10:0] MAX_P  = 11'(MAX_LINE);
  localparam logic [9:0]  MAX_C  = 10'(MAX_LINE);
  localparam logic [8:0]  DEF_L  = 9'(DEF_OUT_LEN);
  localparam logic [8:0]  HS_C   = 9'(HS_START);
  localparam logic [8:0]  HDS    = 9'(H_DE_START);
  localparam logic [8:0]  HDE    = 9'(H_DE_END);
  localparam logic [9:0]  VDS    = 10'(V_DE_START);
  localparam logic [9:0]  VDE    = 10'(V_DE_END);
  localparam logic [2:0]  LOCK_N = 3'(LOCK_LINES);
  logic        line_start, vsync_start, vsync_end;
  logic [9:0]  in_col, line_cnt_n;
  logic        bank, good, near, wrap, watchdog;
  logic [8:0]  out_col, out_col_n, out_len, cur_len;
  logic [10:0] period, prev, diff;
  logic [2:0]  cnt;
  lock_state_t state;
  sd_sync_decode #(.VSYNC_LEN(VSYNC_LEN)) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce_2pix),
    .csync      (csync),
    .line_start (line_start),
    .vsync_start(vsync_start),
    .vsync_end  (vsync_end)
  );
  always_comb begin
    period     = {1'b0, in_col} + 11'd1;
    diff       = (period > prev) ? period - prev : prev - period;
    good       = (period >= MIN_P) && (period <= MAX_P);
    near       = diff <= 11'd2;
    wrap       = out_col == cur_len - 9'd1;
    watchdog   = (in_col == MAX_C) && !line_start;
    out_col_n  = (line_start || wrap) ? '0 : out_col + 9'd1;
    line_cnt_n = vsync_start ? '0 : line_start ? line_cnt + {9'd0, line_cnt != 10'h3ff} : line_cnt;
  end
  // cur_len is the length of the line being emitted; a new out_len only lands at a wrap
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      in_col   <= '0;
      bank     <= 1'b0;
      out_col  <= '0;
      out_len  <= DEF_L;
      cur_len  <= DEF_L;
      state    <= UNLOCKED;
      cnt      <= '0;
      prev     <= '0;
      line_cnt <= '0;
      vs_out   <= 1'b0;
      scanline <= 1'b0;
      hs_out   <= 1'b1;
      de       <= 1'b0;
    end else if (ce_2pix) begin
      in_col   <= (line_start || vsync_end) ? '0 : in_col + {9'd0, in_col != 10'h3ff};
      bank     <= bank ^ line_start;
      out_col  <= out_col_n;
      cur_len  <= wrap ? out_len : cur_len;
      line_cnt <= line_cnt_n;
      vs_out   <= vsync_start | (vs_out & ~csync);
      scanline <= vsync_start ? 1'b0 : scanline ^ wrap;
      hs_out   <= out_col_n < HS_C;
      de       <= (out_col_n >= HDS) && (out_col_n < HDE) && (line_cnt_n >= VDS) && (line_cnt_n < VDE);
      prev     <= line_start ? period : prev;
      case (state)
        UNLOCKED: if (line_start && good) begin
          state <= ACQUIRE;
          cnt   <= 3'd1;
        end
        ACQUIRE: if (line_start) begin
          if (!good || !near) begin
            state <= UNLOCKED;
            cnt   <= '0;
          end else if (cnt + 3'd1 == LOCK_N) begin
            state   <= LOCKED;
            cnt     <= '0;
            out_len <= period[9:1];
          end else cnt <= cnt + 3'd1;
        end
        LOCKED: if (watchdog || (line_start && !good)) begin
          state   <= UNLOCKED;
          out_len <= DEF_L;
        end
        default: state <= UNLOCKED;
      endcase
    end
  assign wr_en   = in_col[0];
  assign wr_addr = {bank, in_col[9:1]};
  assign rd_addr = {~bank, out_col};
  assign locked  = state == LOCKED;
endmodule

// File: tb/tb_sd_line_ctrl.sv
// tb_sd_line_ctrl: directed line-table and sequence checks for sd_line_ctrl
module tb_sd_line_ctrl;
  logic       clk = 1'b0, reset_n = 1'b0, ce_2pix = 1'b1, csync = 1'b1;
  logic       wr_en, hs_out, vs_out, de, scanline, locked;
  logic [9:0] wr_addr, rd_addr, line_cnt;
  int errors = 0, checks = 0;

  sd_line_ctrl dut (
    .clk(clk), .reset_n(reset_n), .ce_2pix(ce_2pix), .csync(csync),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .hs_out(hs_out),
    .vs_out(vs_out), .de(de), .scanline(scanline), .locked(locked), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   lo;
    int   hi;
    logic exp_lock;
    logic exp_bank;
  } line_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic cs);
    csync = cs;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic cs, input int n);
    repeat (n) tick(cs);
  endtask

  // one line: 1 low tick, then 400 high ticks sampled against the column window
  task automatic check_line(input logic v_on, input string name);
    int e_de = 0, e_hs = 0;
    logic exp_de;
    tick(1'b0);
    for (int j = 0; j < 400; j++) begin
      tick(1'b1);
      exp_de = v_on && j >= 64 && j < 364;
      if (de !== exp_de) e_de++;
      if (hs_out !== (j < 384)) e_hs++;
    end
    chk({name, "_de"}, e_de, 0);
    chk({name, "_hs"}, e_hs, 0);
  endtask

  initial begin
    line_vec_t lv[18];
    int e_col = 0, e_hs = 0, e_sc = 0, max_col = 0, hs_lo = 0, sc_tg = 0;
    logic exp_sc, last_sc;
    logic [9:0] wa;
    for (int i = 0; i < 18; i++) begin
      lv[i].lo = 40;
      lv[i].hi = (i < 10) ? 788 : 760;
      lv[i].exp_bank = ((i + 1) % 2) == 1;
      lv[i].exp_lock = (i >= 4 && i <= 8) || i >= 15;
    end
    lv[6].hi = 790;
    lv[8].hi = 360;

    run(1'b1, 5);
    chk("rst_hs", hs_out, 1);
    chk("rst_vs", vs_out, 0);
    chk("rst_lock", locked, 0);
    chk("rst_rd", rd_addr, 10'h200);
    chk("rst_wr", {wr_en, wr_addr}, 0);
    chk("rst_misc", {de, scanline, line_cnt}, 0);

    reset_n = 1'b1;
    for (int j = 1; j <= 1100; j++) begin
      tick(1'b1);
      exp_sc = ((j / 414) % 2) == 1;
      if (rd_addr !== {1'b1, 9'(j % 414)}) e_col++;
      if (hs_out !== ((j % 414) < 384)) e_hs++;
      if (scanline !== exp_sc) e_sc++;
    end
    chk("idle_col", e_col, 0);
    chk("idle_hs", e_hs, 0);
    chk("idle_scan", e_sc, 0);

    for (int i = 0; i < 18; i++) begin
      run(1'b0, lv[i].lo);
      run(1'b1, lv[i].hi);
      chk($sformatf("line%0d_lock", i + 1), locked, lv[i].exp_lock);
      chk($sformatf("line%0d_bank", i + 1), {wr_addr[9], rd_addr[9]}, {lv[i].exp_bank, ~lv[i].exp_bank});
      chk($sformatf("line%0d_wcol", i + 1), {wr_en, wr_addr[8:0]}, {1'(lv[i].hi - 1), 9'((lv[i].hi - 1) >> 1)});
    end

    last_sc = scanline;
    for (int j = 0; j < 800; j++) begin
      tick(j >= 40);
      if (int'(rd_addr[8:0]) > max_col) max_col = int'(rd_addr[8:0]);
      if (!hs_out) hs_lo++;
      if (scanline !== last_sc) sc_tg++;
      last_sc = scanline;
    end
    chk("len400_max", max_col, 399);
    chk("len400_hs", hs_lo, 32);
    chk("len400_scan", sc_tg, 2);

    run(1'b0, 40);
    for (int k = 1; k <= 1100; k++) begin
      tick(1'b1);
      if (k == 1001) chk("wdog_before", locked, 1);
      if (k == 1002) chk("wdog_after", locked, 0);
    end

    chk("pre_rst_wr", wr_addr[8:0], 511);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wr", {wr_en, wr_addr}, 0);
    chk("mid_rst_rd", rd_addr, 10'h200);
    chk("mid_rst_hs", hs_out, 1);
    #1;
    reset_n = 1'b1;

    run(1'b1, 500);
    chk("scan_set", scanline, 1);
    repeat (3) begin
      tick(1'b0);
      run(1'b1, 5);
    end
    chk("pre_vs_cnt", line_cnt, 3);
    run(1'b0, 50);
    ce_2pix = 1'b0;
    wa = wr_addr;
    run(1'b0, 10);
    chk("ce_hold", wr_addr, wa);
    ce_2pix = 1'b1;
    run(1'b0, 40);
    chk("vs_90", vs_out, 0);
    tick(1'b0);
    chk("vs_91", vs_out, 1);
    chk("vs_cnt", line_cnt, 0);
    chk("vs_scan", scanline, 0);
    run(1'b0, 29);
    chk("vs_120", vs_out, 1);
    tick(1'b1);
    chk("vs_fall", vs_out, 0);
    chk("vs_bank", wr_addr, 10'h200);
    chk("vs_cnt_hold", line_cnt, 0);

    repeat (14) begin
      tick(1'b0);
      run(1'b1, 3);
    end
    check_line(1'b0, "v15");
    chk("cnt15", line_cnt, 15);
    check_line(1'b1, "v16");
    repeat (278) begin
      tick(1'b0);
      run(1'b1, 3);
    end
    check_line(1'b1, "v295");
    check_line(1'b0, "v296");
    chk("cnt296", line_cnt, 296);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
